shift_serializer_ctrl: RTL and testbench
========================================

// Module: shift_serializer_ctrl
// PURPOSE
//   Controller that sequences a parallel-load / shift-right register to serialise words.
//   Accepts one WIDTH-bit word per valid/ready handshake and shifts it out LSB first.
//   Each bit is held CLKS_PER_BIT cycles; GAP_CYCLES idle cycles follow each frame.
//   Sits between a word producer and a serial line / bit-consumer; replaces free-running shift use.
// PARAMETERS
//   WIDTH         4   word width in bits (>=2)
//   CLKS_PER_BIT  1   clock cycles each bit is held on ser_out (>=1)
//   GAP_CYCLES    1   idle cycles inserted after each frame (>=0)
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous, active-low reset
//   in_valid   in   1      producer has a word on in_data
//   in_ready   out  1      controller can accept a word (registered)
//   in_data    in   WIDTH  parallel word, sampled on accept
//   abort      in   1      synchronous frame abort
//   ser_out    out  1      current serial bit (0 when ser_valid=0)
//   ser_valid  out  1      ser_out carries a frame bit
//   ser_first  out  1      high for all cycles of bit 0
//   ser_last   out  1      high for all cycles of bit WIDTH-1
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse: frame completed (not on abort)
// BEHAVIOUR
//   - Reset (reset_n=0): state IDLE; all outputs 0, including in_ready; shift reg and counters cleared.
//   - First clock edge after reset release: in_ready rises to 1; no accept is possible before it.
//   - States: IDLE -> SHIFT -> GAP -> IDLE. GAP is skipped when GAP_CYCLES=0.
//   - IDLE: in_ready=1. Accept = in_valid & in_ready at edge E0. At E0: load in_data,
//     in_ready->0, enter SHIFT.
//   - SHIFT: from cycle after E0: ser_valid=1, ser_out=sr[0]; bit_cnt 0..WIDTH-1, cyc_cnt 0..CLKS_PER_BIT-1.
//     On cyc_cnt wrap: shift right (MSB fill 0), bit_cnt++.
//     Total SHIFT time = WIDTH*CLKS_PER_BIT cycles; first-bit latency = 1 cycle after accept.
//   - End of the last bit: done=1 for the next cycle. Enter GAP, or IDLE (in_ready=1 same cycle) if GAP_CYCLES=0.
//   - GAP: ser_valid=0 for GAP_CYCLES cycles, then IDLE with in_ready=1.
//   - Frame period = WIDTH*CLKS_PER_BIT + GAP_CYCLES + 1 cycles when in_valid is held high.
//   - in_data / in_valid changes while busy: ignored. No buffering; in_ready is the only backpressure.
//   - abort in SHIFT or GAP: next cycle IDLE, in_ready=1, ser_* = 0, sr cleared, no done.
//   - abort in IDLE: no effect; a same-cycle accept still proceeds.
//   - Async reset mid-frame: immediate return to reset values; frame dropped silently.
//   - Counter widths: $clog2(WIDTH), $clog2(CLKS_PER_BIT) (min 1), $clog2(GAP_CYCLES) (min 1).
//     All counters compare against terminal values; no wrap beyond terminal.
// STRUCTURE
//   - Package shift_ctrl_pkg: state enum typedef (IDLE, SHIFT, GAP) and localparam encodings.
//   - Sub-module shift_reg_en: WIDTH-bit register with async active-low clear, load, shift_en, and sync clr.
//     Priority: clr > load > shift_en > hold.
//   - Top: FSM, three counters, registered in_ready/done, and output decode.
// TESTING (WIDTH=4, CLKS_PER_BIT=1, GAP_CYCLES=1 unless noted)
//   1. Accept 4'b1011 at edge 0 -> ser_out 1,1,0,1 in cycles 1-4; ser_first cycle 1;
//      ser_last cycle 4; done cycle 5; in_ready=1 cycle 6.
//   2. in_valid held high with 4'hA then 4'h5 -> second accept at edge 6;
//      bits 1,0,1,0 in cycles 7-10; period 6.
//   3. CLKS_PER_BIT=3, GAP_CYCLES=0, word 4'b0001 -> ser_out=1 cycles 1-3, then 0 cycles 4-12;
//      done and in_ready cycle 13.
//   4. abort asserted in cycle 2 of frame 4'hF -> cycle 3: ser_valid=0, in_ready=1; done never pulses.
//   5. reset_n low in cycle 3 of a frame -> all outputs 0 immediately; after release,
//      in_ready=1 one edge later; next frame is clean.
//   6. in_valid=1 during reset and on the release edge -> no accept until in_ready=1;
//      in_data changed mid-frame -> serial bits unaffected.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift serializer controller.
// State encoding and counter-width helper used by the FSM.
package shift_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counters for a range of n values need at least one bit even when n <= 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_reg_en.sv
// WIDTH-bit parallel-load / shift-right register, LSB leaves first.
// Priority: clr > load > shift_en > hold.
module shift_reg_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_serializer_ctrl.sv
// Serialises one WIDTH-bit word per valid/ready handshake, LSB first,
// holding each bit CLKS_PER_BIT cycles and idling GAP_CYCLES after each frame.
module shift_serializer_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = cnt_width(WIDTH);
    localparam int CYC_W = cnt_width(CLKS_PER_BIT);
    localparam int GAP_W = cnt_width(GAP_CYCLES);

    state_t           state;
    logic [BIT_W-1:0] bit_cnt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [WIDTH-1:0] sr;

    logic bit_last, cyc_last, gap_last;
    logic accept, sr_clr, sr_shift;

    assign bit_last = (bit_cnt == BIT_W'(WIDTH - 1));
    assign cyc_last = (cyc_cnt == CYC_W'(CLKS_PER_BIT - 1));
    assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // Abort only matters once a frame is in flight; in IDLE an accept still wins.
    always_comb begin
        accept   = 1'b0;
        sr_clr   = 1'b0;
        sr_shift = 1'b0;
        if (state == IDLE) begin
            accept = in_valid && in_ready;
        end else begin
            sr_clr   = abort;
            sr_shift = (state == SHIFT) && cyc_last && !abort;
        end
    end

    shift_reg_en #(.WIDTH(WIDTH)) u_sr (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (sr_clr),
        .load     (accept),
        .shift_en (sr_shift),
        .d        (in_data),
        .q        (sr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        bit_cnt  <= '0;
                        cyc_cnt  <= '0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        bit_cnt  <= '0;
                        cyc_cnt  <= '0;
                    end else if (cyc_last) begin
                        cyc_cnt <= '0;
                        if (bit_last) begin
                            done    <= 1'b1;
                            bit_cnt <= '0;
                            if (GAP_CYCLES == 0) begin
                                state    <= IDLE;
                                in_ready <= 1'b1;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (abort || gap_last) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ser_valid = (state == SHIFT);
        ser_out   = ser_valid && sr[0];
        ser_first = ser_valid && (bit_cnt == '0);
        ser_last  = ser_valid && bit_last;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_shift_serializer_ctrl.sv
// Scoreboard bench for shift_serializer_ctrl: one instance with 1 clk/bit and a 1-cycle gap,
// one with 3 clks/bit and no gap; a monitor pops expected {bit,first,last} per valid cycle.
module tb_shift_serializer_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic       a_valid = 1'b0, a_abort = 1'b0;
    logic [3:0] a_data = '0;
    logic       a_ready, a_ser, a_sv, a_first, a_last, a_busy, a_done;

    logic       b_valid = 1'b0, b_abort = 1'b0;
    logic [3:0] b_data = '0;
    logic       b_ready, b_ser, b_sv, b_first, b_last, b_busy, b_done;

    int checks = 0;
    int passed = 0;

    logic [2:0] qa[$];
    logic [2:0] qb[$];

    always #5 clk = ~clk;

    shift_serializer_ctrl #(.WIDTH(4), .CLKS_PER_BIT(1), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .abort(a_abort), .ser_out(a_ser), .ser_valid(a_sv),
        .ser_first(a_first), .ser_last(a_last), .busy(a_busy), .done(a_done)
    );

    shift_serializer_ctrl #(.WIDTH(4), .CLKS_PER_BIT(3), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .abort(b_abort), .ser_out(b_ser), .ser_valid(b_sv),
        .ser_first(b_first), .ser_last(b_last), .busy(b_busy), .done(b_done)
    );

    task automatic push_bits(input logic [3:0] w, input int cpb, input bit to_b);
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < cpb; c++) begin
                if (to_b) qb.push_back({w[i], i == 0, i == 3});
                else      qa.push_back({w[i], i == 0, i == 3});
            end
        end
    endtask

    // Serial-side monitor: every cycle either pops an expected bit or requires an idle line.
    always @(negedge clk) begin : monitor
        logic [2:0] e;
        if (reset_n) begin
            checks++;
            if (a_sv) begin
                if (qa.size() == 0) begin
                    $display("FAIL mon_a_unexpected got=%b%b%b exp=none", a_ser, a_first, a_last);
                end else begin
                    e = qa.pop_front();
                    if ({a_ser, a_first, a_last} !== e)
                        $display("FAIL mon_a_bit t=%0t got=%b%b%b exp=%b", $time, a_ser, a_first, a_last, e);
                    else passed++;
                end
            end else if ({a_ser, a_first, a_last} !== 3'b000) begin
                $display("FAIL mon_a_idle got=%b%b%b exp=000", a_ser, a_first, a_last);
            end else passed++;

            checks++;
            if (b_sv) begin
                if (qb.size() == 0) begin
                    $display("FAIL mon_b_unexpected got=%b%b%b exp=none", b_ser, b_first, b_last);
                end else begin
                    e = qb.pop_front();
                    if ({b_ser, b_first, b_last} !== e)
                        $display("FAIL mon_b_bit t=%0t got=%b%b%b exp=%b", $time, b_ser, b_first, b_last, e);
                    else passed++;
                end
            end else if ({b_ser, b_first, b_last} !== 3'b000) begin
                $display("FAIL mon_b_idle got=%b%b%b exp=000", b_ser, b_first, b_last);
            end else passed++;
        end
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({a_ready, a_ser, a_sv, a_first, a_last, a_busy, a_done} !== 7'b0)
            $display("FAIL reset_a_outputs got=%b exp=0000000", {a_ready, a_ser, a_sv, a_first, a_last, a_busy, a_done});
        else passed++;
        checks++;
        if ({b_ready, b_ser, b_sv, b_first, b_last, b_busy, b_done} !== 7'b0)
            $display("FAIL reset_b_outputs got=%b exp=0000000", {b_ready, b_ser, b_sv, b_first, b_last, b_busy, b_done});
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) $display("FAIL release_ready_early got=%b exp=0", a_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if ({a_ready, b_ready} !== 2'b11) $display("FAIL release_ready got=%b exp=11", {a_ready, b_ready});
        else passed++;
    endtask

    task automatic test_single_frame();
        a_valid = 1'b1;
        a_data  = 4'b1011;
        push_bits(4'b1011, 1, 1'b0);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) a_valid = 1'b0;
            checks++;
            if (a_done !== (n == 5)) $display("FAIL single_done n=%0d got=%b exp=%b", n, a_done, n == 5);
            else passed++;
            checks++;
            if (a_ready !== (n >= 6)) $display("FAIL single_ready n=%0d got=%b exp=%b", n, a_ready, n >= 6);
            else passed++;
            checks++;
            if (a_sv !== (n <= 4)) $display("FAIL single_valid n=%0d got=%b exp=%b", n, a_sv, n <= 4);
            else passed++;
            checks++;
            if (a_busy !== (n <= 5)) $display("FAIL single_busy n=%0d got=%b exp=%b", n, a_busy, n <= 5);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        a_valid = 1'b1;
        a_data  = 4'hA;
        push_bits(4'hA, 1, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) a_data = 4'h5;
            if (n == 6) push_bits(4'h5, 1, 1'b0);
            if (n == 7) a_valid = 1'b0;
            checks++;
            if (a_ready !== (n == 6 || n == 12)) $display("FAIL b2b_ready n=%0d got=%b exp=%b", n, a_ready, n == 6 || n == 12);
            else passed++;
            checks++;
            if (a_done !== (n == 5 || n == 11)) $display("FAIL b2b_done n=%0d got=%b exp=%b", n, a_done, n == 5 || n == 11);
            else passed++;
            checks++;
            if (a_sv !== ((n >= 1 && n <= 4) || (n >= 7 && n <= 10)))
                $display("FAIL b2b_valid n=%0d got=%b", n, a_sv);
            else passed++;
        end
    endtask

    task automatic test_slow_no_gap();
        b_valid = 1'b1;
        b_data  = 4'b0001;
        push_bits(4'b0001, 3, 1'b1);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) b_valid = 1'b0;
            checks++;
            if (b_done !== (n == 13)) $display("FAIL slow_done n=%0d got=%b exp=%b", n, b_done, n == 13);
            else passed++;
            checks++;
            if (b_ready !== (n >= 13)) $display("FAIL slow_ready n=%0d got=%b exp=%b", n, b_ready, n >= 13);
            else passed++;
            checks++;
            if (b_sv !== (n <= 12)) $display("FAIL slow_valid n=%0d got=%b exp=%b", n, b_sv, n <= 12);
            else passed++;
        end
    endtask

    task automatic test_abort();
        a_valid = 1'b1;
        a_data  = 4'hF;
        qa.push_back(3'b110);
        qa.push_back(3'b100);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) a_valid = 1'b0;
            if (n == 3) begin
                a_abort = 1'b0;
                checks++;
                if ({a_sv, a_ready, a_busy} !== 3'b010)
                    $display("FAIL abort_state got=%b exp=010", {a_sv, a_ready, a_busy});
                else passed++;
            end
            if (n == 2) a_abort = 1'b1;
            checks++;
            if (a_done !== 1'b0) $display("FAIL abort_done n=%0d got=%b exp=0", n, a_done);
            else passed++;
        end
        // abort while idle must not block a same-cycle accept
        a_abort = 1'b1;
        a_valid = 1'b1;
        a_data  = 4'b0110;
        push_bits(4'b0110, 1, 1'b0);
        @(negedge clk);
        a_abort = 1'b0;
        a_valid = 1'b0;
        checks++;
        if ({a_sv, a_busy, a_ready} !== 3'b110)
            $display("FAIL abort_idle_accept got=%b exp=110", {a_sv, a_busy, a_ready});
        else passed++;
        for (int n = 2; n <= 6; n++) begin
            @(negedge clk);
            checks++;
            if (a_done !== (n == 5)) $display("FAIL abort_idle_done n=%0d got=%b exp=%b", n, a_done, n == 5);
            else passed++;
        end
        checks++;
        if (a_ready !== 1'b1) $display("FAIL abort_idle_ready got=%b exp=1", a_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        a_valid = 1'b1;
        a_data  = 4'b1101;
        qa.push_back(3'b110);
        qa.push_back(3'b000);
        qa.push_back(3'b100);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_ser, a_sv, a_first, a_last, a_busy, a_done} !== 7'b0)
            $display("FAIL midreset_outputs got=%b exp=0000000", {a_ready, a_ser, a_sv, a_first, a_last, a_busy, a_done});
        else passed++;
        checks++;
        if (qa.size() != 0) $display("FAIL midreset_queue got=%0d exp=0", qa.size());
        else passed++;
        @(negedge clk);
        @(negedge clk);
        a_data  = 4'b1001;
        reset_n = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) $display("FAIL midreset_ready_early got=%b exp=0", a_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if ({a_ready, a_sv, a_busy} !== 3'b100)
            $display("FAIL release_no_accept got=%b exp=100", {a_ready, a_sv, a_busy});
        else passed++;
        push_bits(4'b1001, 1, 1'b0);
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = 4'b0110;
        checks++;
        if ({a_sv, a_first, a_ready} !== 3'b110)
            $display("FAIL post_reset_accept got=%b exp=110", {a_sv, a_first, a_ready});
        else passed++;
        for (int n = 2; n <= 6; n++) begin
            @(negedge clk);
            checks++;
            if (a_done !== (n == 5)) $display("FAIL post_reset_done n=%0d got=%b exp=%b", n, a_done, n == 5);
            else passed++;
            checks++;
            if (a_ready !== (n == 6)) $display("FAIL post_reset_ready n=%0d got=%b exp=%b", n, a_ready, n == 6);
            else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_slow_no_gap();
        test_abort();
        test_reset_mid_frame();
        @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0)
            $display("FAIL queues_drained got=%0d/%0d exp=0/0", qa.size(), qb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
